// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Purpose  : Pipelined NUM_SPR-sprite pixel compositor. Stage S0 computes each
//            sprite's region hit and ROM address, a delay line waits out the
//            ROM latency, stage S1 merges the sprites by fixed priority
//            (index 0 highest) over the background pixel. Each sprite has a
//            4-bit hit-flash counter decremented once per frame.
// Ports    : clk, rst_l (async, active low)
//            bright, hCount, vCount, bg_rgb  : upstream timing + background
//            spr_x, spr_y                    : sprite top-left, 10 b each
//            hit_pulse                       : start flash per sprite
//            spr_flip                        : mirror per sprite (macro only)
//            rom_addr / rom_pixel            : sprite ROM interface
//            rgb                             : composited pixel out
// Config   : SPRITE_MIRROR_EN enables spr_flip and horizontal mirroring.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
    parameter int NUM_SPR      = 2,
    parameter int SPR_W        = 128,
    parameter int SPR_H        = 128,
    parameter int AW           = 14,
    parameter int ROM_LAT      = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  bright,
    input  logic [9:0]            hCount,
    input  logic [9:0]            vCount,
    input  logic [11:0]           bg_rgb,
    input  logic [NUM_SPR*10-1:0] spr_x,
    input  logic [NUM_SPR*10-1:0] spr_y,
    input  logic [NUM_SPR-1:0]    hit_pulse,
`ifdef SPRITE_MIRROR_EN
    input  logic [NUM_SPR-1:0]    spr_flip,
`endif
    output logic [NUM_SPR*AW-1:0] rom_addr,
    input  logic [NUM_SPR*12-1:0] rom_pixel,
    output logic [11:0]           rgb
);

    localparam int LXW = $clog2(SPR_W);
    localparam int LYW = $clog2(SPR_H);

    // S0 combinational results
    logic [NUM_SPR-1:0]    region_d;
    logic [NUM_SPR*AW-1:0] addr_d;

    // Pipeline state: index 0 is the S0 register, index ROM_LAT lines up
    // with rom_pixel.
    logic [NUM_SPR*AW-1:0] rom_addr_q;
    logic                  bright_q [0:ROM_LAT];
    logic [NUM_SPR-1:0]    region_q [0:ROM_LAT];
    logic [11:0]           bg_q     [0:ROM_LAT];

    logic                  origin_q;
    logic                  origin_qq;
    logic                  frame_tick;

    logic [NUM_SPR-1:0]    opaque;
    logic [NUM_SPR-1:0]    flash_on;
    logic [11:0]           rgb_d;
    logic [11:0]           rgb_q;

    // Edge detect of the registered origin flag: one tick per frame even if
    // the timing generator holds hCount/vCount at 0 for several clocks.
    assign frame_tick = origin_q & ~origin_qq;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        logic [10:0]    h11, v11, x11, y11;
        logic [LXW-1:0] dx;
        logic [LXW-1:0] lx;
        logic [LYW-1:0] ly;
        logic [3:0]     cnt_q, cnt_d;

        // 11-bit compare so x+SPR_W past 1023 does not wrap around.
        assign h11 = {1'b0, hCount};
        assign v11 = {1'b0, vCount};
        assign x11 = {1'b0, spr_x[10*i +: 10]};
        assign y11 = {1'b0, spr_y[10*i +: 10]};

        assign region_d[i] = (h11 >= x11) && (h11 < x11 + 11'(SPR_W)) &&
                             (v11 >= y11) && (v11 < y11 + 11'(SPR_H));

        assign dx = LXW'(hCount - spr_x[10*i +: 10]);
        assign ly = LYW'(vCount - spr_y[10*i +: 10]);
`ifdef SPRITE_MIRROR_EN
        // SPR_W-1-dx in LXW bits is just the bitwise inverse of dx.
        assign lx = spr_flip[i] ? ~dx : dx;
`else
        assign lx = dx;
`endif
        // SPR_W is a power of two, so ly*SPR_W+lx is a concatenation.
        assign addr_d[i*AW +: AW] = region_d[i] ? AW'({ly, lx}) : '0;

        // Colour keys 0x00C..0x00F are transparent.
        assign opaque[i] = region_q[ROM_LAT][i] &&
                           !((rom_pixel[12*i+4 +: 8] == 8'h00) &&
                             (rom_pixel[12*i+2 +: 2] == 2'b11));

        // Hit load has priority over the frame decrement.
        always_comb begin
            cnt_d = cnt_q;
            if (hit_pulse[i]) begin
                cnt_d = 4'(FLASH_FRAMES);
            end else if (frame_tick && (cnt_q != 4'd0)) begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                cnt_q <= 4'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign flash_on[i] = (cnt_q != 4'd0) && cnt_q[0];
    end

    // S0 registers, ROM-latency delay line and frame-origin flags
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rom_addr_q <= '0;
            origin_q   <= 1'b0;
            origin_qq  <= 1'b0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                bright_q[k] <= 1'b0;
                region_q[k] <= '0;
                bg_q[k]     <= 12'h000;
            end
        end else begin
            rom_addr_q  <= addr_d;
            bright_q[0] <= bright;
            region_q[0] <= region_d;
            bg_q[0]     <= bg_rgb;
            origin_q    <= (hCount == 10'd0) && (vCount == 10'd0);
            origin_qq   <= origin_q;
            for (int k = 1; k <= ROM_LAT; k++) begin
                bright_q[k] <= bright_q[k-1];
                region_q[k] <= region_q[k-1];
                bg_q[k]     <= bg_q[k-1];
            end
        end
    end

    // S1 compose: walk from lowest to highest priority so index 0 wins.
    always_comb begin
        rgb_d = bg_q[ROM_LAT];
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                rgb_d = flash_on[i] ? 12'hFFF : rom_pixel[12*i +: 12];
            end
        end
        if (!bright_q[ROM_LAT]) begin
            rgb_d = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rgb      = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor
// Purpose  : Self-checking bench for sprite_compositor (default parameters).
//            A behavioural ROM feeds rom_pixel with one cycle of latency; the
//            expected pixel is computed from sprite geometry and ROM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;

    localparam int LAT = 3;   // ROM_LAT + 2

    logic        clk = 1'b0;
    logic        rst_l;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic [11:0] bg_rgb;
    logic [19:0] spr_x, spr_y;
    logic [1:0]  hit_pulse;
    logic [1:0]  spr_flip;
    logic [27:0] rom_addr;
    logic [23:0] rom_pixel;
    logic [11:0] rgb;

    logic [11:0] rom [2][16384];

    int errors = 0;
    int checks = 0;
    int exp_cnt;

    sprite_compositor dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .bright    (bright),
        .hCount    (hCount),
        .vCount    (vCount),
        .bg_rgb    (bg_rgb),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .hit_pulse (hit_pulse),
`ifdef SPRITE_MIRROR_EN
        .spr_flip  (spr_flip),
`endif
        .rom_addr  (rom_addr),
        .rom_pixel (rom_pixel),
        .rgb       (rgb)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROMs, one cycle read latency
    always @(posedge clk) begin
        rom_pixel <= {rom[1][rom_addr[27:14]], rom[0][rom_addr[13:0]]};
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference pixel from geometry: topmost opaque sprite, else background.
    function automatic logic [11:0] ref_rgb(input logic br, input logic [9:0] h10,
                                            input logic [9:0] v10, input logic [11:0] bg,
                                            input logic [19:0] xs, input logic [19:0] ys);
        logic [11:0] res;
        logic [11:0] p;
        int h, v, x, y;
        h = int'(h10);
        v = int'(v10);
        res = bg;
        for (int s = 1; s >= 0; s--) begin
            x = int'(xs[s*10 +: 10]);
            y = int'(ys[s*10 +: 10]);
            if (h >= x && h < x + 128 && v >= y && v < y + 128) begin
                p = rom[s][(v - y) * 128 + (h - x)];
                if (!(p[11:4] == 8'h00 && p[3:2] == 2'b11)) res = p;
            end
        end
        if (!br) res = 12'h000;
        return res;
    endfunction

    task automatic test_reset;
        rst_l = 1'b0; bright = 1'b0; hCount = 10'd0; vCount = 10'd0;
        bg_rgb = 12'h5A5; spr_x = {10'd1000, 10'd1000}; spr_y = 20'd0;
        hit_pulse = 2'b00; spr_flip = 2'b00;
        step(3);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
        checks++; if (rom_addr !== 28'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", rom_addr); end
        rst_l = 1'b1;
        step(4);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL post_reset_rgb got=%h exp=000", rgb); end
        checks++; if (rom_addr !== 28'd0) begin errors++; $display("FAIL post_reset_addr got=%h exp=0", rom_addr); end
    endtask

    task automatic test_address_latency;
        spr_x = {10'd1000, 10'd100}; spr_y = {10'd0, 10'd50};
        bright = 1'b0; rom[0][257] = 12'hF80;
        step(4);
        hCount = 10'd101; vCount = 10'd52; bright = 1'b1; bg_rgb = 12'h111;
        step(1);
        checks++; if (rom_addr[13:0] !== 14'd257) begin errors++; $display("FAIL addr0 got=%0d exp=257", rom_addr[13:0]); end
        bright = 1'b0;
        step(1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_early got=%h exp=000", rgb); end
        step(1);
        checks++; if (rgb !== 12'hF80) begin errors++; $display("FAIL lat_pixel got=%h exp=F80", rgb); end
        step(1);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL lat_late got=%h exp=000", rgb); end
    endtask

    task automatic test_overlap;
        spr_x = {10'd200, 10'd200}; spr_y = {10'd100, 10'd100};
        hCount = 10'd210; vCount = 10'd110; bright = 1'b1; bg_rgb = 12'h777;
        rom[0][1290] = 12'h00D; rom[1][1290] = 12'h0A0;
        step(4);
        checks++; if (rgb !== 12'h0A0) begin errors++; $display("FAIL overlap_transp got=%h exp=0A0", rgb); end
        rom[0][1290] = 12'h123;
        step(4);
        checks++; if (rgb !== 12'h123) begin errors++; $display("FAIL overlap_prio got=%h exp=123", rgb); end
        rom[0][1290] = 12'h00B;
        step(4);
        checks++; if (rgb !== 12'h00B) begin errors++; $display("FAIL key_edge got=%h exp=00B", rgb); end
        rom[0][1290] = 12'h00C; rom[1][1290] = 12'h00F;
        step(4);
        checks++; if (rgb !== 12'h777) begin errors++; $display("FAIL both_transp got=%h exp=777", rgb); end
    endtask

    task automatic test_edges;
        spr_x = {10'd1000, 10'd100}; spr_y = {10'd0, 10'd50};
        bright = 1'b1; bg_rgb = 12'h246; rom[0][16383] = 12'h5A1;
        hCount = 10'd227; vCount = 10'd177;
        step(4);
        checks++; if (rgb !== 12'h5A1) begin errors++; $display("FAIL edge_in got=%h exp=5A1", rgb); end
        hCount = 10'd228;
        step(4);
        checks++; if (rgb !== 12'h246) begin errors++; $display("FAIL edge_right got=%h exp=246", rgb); end
        hCount = 10'd99; vCount = 10'd60;
        step(4);
        checks++; if (rgb !== 12'h246) begin errors++; $display("FAIL edge_left got=%h exp=246", rgb); end
    endtask

    task automatic test_no_wrap;
        spr_x = {10'd1000, 10'd1000}; spr_y = 20'd0;
        bright = 1'b0;
        step(3);
        hCount = 10'd5; vCount = 10'd5; bg_rgb = 12'hC3E; bright = 1'b1;
        step(1);
        checks++; if (rom_addr !== 28'd0) begin errors++; $display("FAIL nowrap_addr got=%h exp=0", rom_addr); end
        bright = 1'b0; bg_rgb = 12'h000;
        step(2);
        checks++; if (rgb !== 12'hC3E) begin errors++; $display("FAIL nowrap_rgb got=%h exp=C3E", rgb); end
    endtask

    task automatic test_random;
        logic [11:0] q[$];
        logic [11:0] e;
        int x0, y0;
        for (int i = 0; i < 402; i++) begin
            if (i < 400) begin
                x0 = int'($urandom_range(0, 700));
                y0 = int'($urandom_range(0, 420));
                spr_x  = {10'(x0 + int'($urandom_range(0, 120))), 10'(x0)};
                spr_y  = {10'(y0 + int'($urandom_range(0, 120))), 10'(y0)};
                hCount = 10'(x0 + int'($urandom_range(0, 260)) - 40);
                vCount = 10'(y0 + int'($urandom_range(0, 260)) - 40);
                bright = ($urandom_range(0, 7) != 0);
                bg_rgb = 12'($urandom);
            end else begin
                bright = 1'b0;
            end
            q.push_back(ref_rgb(bright, hCount, vCount, bg_rgb, spr_x, spr_y));
            step(1);
            if (q.size() >= LAT) begin
                e = q.pop_front();
                checks++;
                if (rgb !== e) begin errors++; $display("FAIL random[%0d] got=%h exp=%h", i, rgb, e); end
            end
        end
    endtask

    task automatic test_flash;
        spr_x = {10'd1000, 10'd0}; spr_y = 20'd0;
        hCount = 10'd5; vCount = 10'd5; bright = 1'b1; bg_rgb = 12'h0C0;
        rom[0][645] = 12'h3A5;
        exp_cnt = 0;
        step(4);
        checks++; if (rgb !== 12'h3A5) begin errors++; $display("FAIL flash_idle got=%h exp=3A5", rgb); end
        hit_pulse = 2'b01; step(1); hit_pulse = 2'b00; exp_cnt = 8;
        step(4);
        checks++; if (rgb !== 12'h3A5) begin errors++; $display("FAIL flash_load got=%h exp=3A5", rgb); end
        for (int t = 0; t < 9; t++) begin
            hCount = 10'd0; vCount = 10'd0; step(1);
            hCount = 10'd5; vCount = 10'd5; step(5);
            if (exp_cnt > 0) exp_cnt--;
            checks++;
            if (rgb !== (exp_cnt[0] ? 12'hFFF : 12'h3A5)) begin
                errors++; $display("FAIL flash_tick[%0d] got=%h cnt=%0d", t, rgb, exp_cnt);
            end
        end
        // held origin gives a single tick: 8 -> 7
        hit_pulse = 2'b01; step(1); hit_pulse = 2'b00;
        hCount = 10'd0; vCount = 10'd0; step(4);
        hCount = 10'd5; vCount = 10'd5; step(5);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL flash_hold got=%h exp=FFF", rgb); end
        // only opaque sprite pixels flash
        hCount = 10'd200; vCount = 10'd200; step(4);
        checks++; if (rgb !== 12'h0C0) begin errors++; $display("FAIL flash_bg got=%h exp=0C0", rgb); end
        // hit coincident with tick: load wins (8), then one tick -> 7
        hCount = 10'd0; vCount = 10'd0; step(1);
        hit_pulse = 2'b01; hCount = 10'd5; vCount = 10'd5; step(1);
        hit_pulse = 2'b00; step(5);
        checks++; if (rgb !== 12'h3A5) begin errors++; $display("FAIL flash_coincide got=%h exp=3A5", rgb); end
        hCount = 10'd0; vCount = 10'd0; step(1);
        hCount = 10'd5; vCount = 10'd5; step(5);
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL flash_after got=%h exp=FFF", rgb); end
    endtask

    task automatic test_reset_mid;
        // counter is 7 here (flashing); async reset must clear everything
        #2 rst_l = 1'b0;
        #1;
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mid_reset_rgb got=%h exp=000", rgb); end
        checks++; if (rom_addr !== 28'd0) begin errors++; $display("FAIL mid_reset_addr got=%h exp=0", rom_addr); end
        @(negedge clk);
        rst_l = 1'b1;
        step(3);
        checks++; if (rgb !== 12'h3A5) begin errors++; $display("FAIL mid_reset_recover got=%h exp=3A5", rgb); end
    endtask

    task automatic test_mirror;
        logic [13:0] exp_a;
`ifdef SPRITE_MIRROR_EN
        exp_a = 14'd127;
`else
        exp_a = 14'd0;
`endif
        spr_x = {10'd1000, 10'd100}; spr_y = {10'd0, 10'd50};
        hCount = 10'd100; vCount = 10'd50; bright = 1'b1; spr_flip = 2'b01;
        step(1);
        checks++; if (rom_addr[13:0] !== exp_a) begin errors++; $display("FAIL mirror_addr got=%0d exp=%0d", rom_addr[13:0], exp_a); end
        spr_flip = 2'b00;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16384; a++) begin
                rom[s][a] = ($urandom_range(0, 3) == 0) ? 12'(12 + $urandom_range(0, 3)) : 12'($urandom);
            end
        end
        test_reset();
        test_address_latency();
        test_overlap();
        test_edges();
        test_no_wrap();
        test_random();
        test_flash();
        test_reset_mid();
        test_mirror();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
